// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the generic pipeline stage register.
// No logic here; state encoding and the control-bundle bit layout.
// Instantiators pack their control fields with the CTRL_* indices below.
package pipe_pkg;

  // Stage occupancy: nothing held / main entry only / main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Control bundle bit positions.
  localparam int CTRL_MEM_READ    = 0;
  localparam int CTRL_MEM_WRITE   = 1;
  localparam int CTRL_MASK_MODE_L = 2;
  localparam int CTRL_MASK_MODE_H = 3;
  localparam int CTRL_SEXT        = 4;
  localparam int CTRL_TO_REG      = 5;
  localparam int CTRL_REG_WRITE   = 6;

  // Width needed to carry every field above; narrower instantiations drop the top bits.
  localparam int CTRL_BUNDLE_W = 7;

  // Control value presented by bubbles: every enable deasserted.
  localparam logic [CTRL_BUNDLE_W-1:0] CTRL_FLUSH_DEF = '0;

endpackage

// File: rtl/pipe_entry.sv
`timescale 1ns/1ps
// One stage entry: payload + control register with load enable.
// Latency: 1 cycle from load to q outputs.
// No handshake of its own; flush clears control and wins over load, payload keeps its value.
module pipe_entry #(
  parameter int                DATA_W         = 32,
  parameter int                CTRL_W         = 6,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Next value: flush only scrubs control, payload is don't-care while invalid.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (flush) begin
      ctrl_d = CTRL_FLUSH_VAL;
    end else if (load) begin
      data_d = d_data;
      ctrl_d = d_ctrl;
    end
  end

  // Entry registers with asynchronous reset to the bubble value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ctrl_q <= CTRL_FLUSH_VAL;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign q_data = data_q;
  assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
// Pipeline stage register with valid/ready handshake and optional 2-entry skid buffer.
// Latency: 1 cycle in->out, 1 beat/cycle sustained while out_ready is high.
// Backpressure: SKID=1 absorbs one extra beat, in_ready registered; SKID=0 in_ready follows out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                CTRL_W         = 6,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH_VAL = CTRL_W'(CTRL_FLUSH_DEF),
  parameter int                SKID           = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_e            state_q, state_d;
  logic              in_xfer, out_xfer;
  logic              main_load, main_from_skid, skid_load;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  // Handshake and output view; bubbles never expose a stale control word.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      in_ready = (state_q != ST_SKID);
    end else begin
      in_ready = (state_q == ST_EMPTY) | out_ready;
    end
    in_xfer  = in_valid & in_ready;
    out_xfer = out_valid & out_ready;
    out_data = main_data;
    out_ctrl = out_valid ? main_ctrl : CTRL_FLUSH_VAL;
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next state and entry load controls; flush drops everything younger than the departing head.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with a skid entry: without one in_ready tracks out_ready here.
            if (SKID != 0) begin
              state_d   = ST_SKID;
              skid_load = 1'b1;
            end
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Main entry refills from the skid entry when draining the second beat.
  always_comb begin
    main_d_data = main_from_skid ? skid_data : in_data;
    main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry #(
    .DATA_W         (DATA_W),
    .CTRL_W         (CTRL_W),
    .CTRL_FLUSH_VAL (CTRL_FLUSH_VAL)
  ) u_main (
    .clk    (clk),
    .rst_n  (reset),
    .flush  (flush),
    .load   (main_load),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .q_data (main_data),
    .q_ctrl (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(
      .DATA_W         (DATA_W),
      .CTRL_W         (CTRL_W),
      .CTRL_FLUSH_VAL (CTRL_FLUSH_VAL)
    ) u_skid (
      .clk    (clk),
      .rst_n  (reset),
      .flush  (flush),
      .load   (skid_load),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .q_data (skid_data),
      .q_ctrl (skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_data = '0;
    assign skid_ctrl = CTRL_FLUSH_VAL;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance on a shared clock and reset.
// Scoreboards push accepted beats and compare the head at the output every cycle.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = CTRL_BUNDLE_W;
  localparam logic [CW-1:0] FV = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_occ;
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_occ;

  int n_chk = 0;
  int n_fail = 0;
  int a_ndel = 0;
  int b_ndel = 0;
  int base;
  logic [CW+DW-1:0] a_q[$];
  logic [CW+DW-1:0] b_q[$];

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_FLUSH_VAL(FV), .SKID(1)) u_dut_a (
    .clk(clk), .reset(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_FLUSH_VAL(FV), .SKID(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the skid build: capacity 2, in_ready only depends on fill level.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
    end else begin
      chk("a_occ", 64'(a_occ), 64'(a_q.size()));
      chk("a_out_valid", 64'(a_out_valid), 64'(a_q.size() != 0));
      chk("a_in_ready", 64'(a_in_ready), 64'(a_q.size() < 2));
      if (a_q.size() != 0) begin
        chk("a_head", 64'({a_out_ctrl, a_out_data}), 64'(a_q[0]));
        if (a_out_ready) begin
          void'(a_q.pop_front());
          a_ndel++;
        end
      end else begin
        chk("a_idle_ctrl", 64'(a_out_ctrl), 64'(FV));
      end
      if (a_flush) a_q.delete();
      else if (a_in_valid && a_in_ready) a_q.push_back({a_in_ctrl, a_in_data});
    end
  end

  // Scoreboard for the single-entry build: accepts when empty or when the head leaves.
  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete();
    end else begin
      chk("b_occ", 64'(b_occ), 64'(b_q.size()));
      chk("b_out_valid", 64'(b_out_valid), 64'(b_q.size() != 0));
      chk("b_in_ready", 64'(b_in_ready), 64'((b_q.size() == 0) || b_out_ready));
      if (b_q.size() != 0) begin
        chk("b_head", 64'({b_out_ctrl, b_out_data}), 64'(b_q[0]));
        if (b_out_ready) begin
          void'(b_q.pop_front());
          b_ndel++;
        end
      end else begin
        chk("b_idle_ctrl", 64'(b_out_ctrl), 64'(FV));
      end
      if (b_flush) b_q.delete();
      else if (b_in_valid && b_in_ready) b_q.push_back({b_in_ctrl, b_in_data});
    end
  end

  initial begin
    a_flush = 0; a_in_valid = 1; a_in_data = 32'hDEAD_BEEF; a_in_ctrl = '1; a_out_ready = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 32'hDEAD_BEEF; b_in_ctrl = '1; b_out_ready = 0;

    // Reset held with a beat offered
    repeat (3) cyc();
    chk("t1_a_out_valid", 64'(a_out_valid), 64'(0));
    chk("t1_a_in_ready", 64'(a_in_ready), 64'(1));
    chk("t1_a_out_ctrl", 64'(a_out_ctrl), 64'(FV));
    chk("t1_a_occ", 64'(a_occ), 64'(0));
    chk("t1_a_out_data", 64'(a_out_data), 64'(0));
    chk("t1_b_out_valid", 64'(b_out_valid), 64'(0));
    chk("t1_b_occ", 64'(b_occ), 64'(0));
    a_in_valid = 0; b_in_valid = 0;
    rst_n = 1;
    cyc();

    // Streaming, 8 back-to-back beats
    a_out_ready = 1;
    base = a_ndel;
    for (int k = 1; k <= 8; k++) begin
      a_in_valid = 1; a_in_data = DW'(k); a_in_ctrl = CW'(k * 5);
      cyc();
    end
    a_in_valid = 0;
    cyc(); cyc();
    chk("t2_delivered", 64'(a_ndel - base), 64'(8));

    // Backpressure into the skid entry
    a_out_ready = 0;
    base = a_ndel;
    a_in_valid = 1; a_in_data = 32'hA0A0_0001; a_in_ctrl = 7'h11; cyc();
    a_in_data = 32'hB0B0_0002; a_in_ctrl = 7'h22; cyc();
    a_in_data = 32'hC0C0_0003; a_in_ctrl = 7'h33; cyc(); cyc();
    chk("t3_occ_full", 64'(a_occ), 64'(2));
    chk("t3_in_ready_low", 64'(a_in_ready), 64'(0));
    a_out_ready = 1; cyc(); cyc();
    a_in_valid = 0; cyc(); cyc();
    chk("t3_delivered", 64'(a_ndel - base), 64'(3));

    // Flush with both entries occupied and regWrite set
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h1111_0001; a_in_ctrl = CW'(1) << CTRL_REG_WRITE; cyc();
    a_in_data = 32'h2222_0002; a_in_ctrl = (CW'(1) << CTRL_REG_WRITE) | CW'(1); cyc();
    chk("t4_pre_occ", 64'(a_occ), 64'(2));
    a_in_data = 32'h3333_0003; a_flush = 1; cyc();
    a_flush = 0; a_in_valid = 0;
    chk("t4_out_valid", 64'(a_out_valid), 64'(0));
    chk("t4_out_ctrl", 64'(a_out_ctrl), 64'(0));
    chk("t4_occ", 64'(a_occ), 64'(0));
    a_out_ready = 1; repeat (3) cyc();
    chk("t4_dropped", 64'(a_out_valid), 64'(0));

    // Flush while the head leaves and a beat is accepted: head delivered, new beat dropped
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h4444_0004; a_in_ctrl = 7'h45; cyc();
    base = a_ndel;
    a_out_ready = 1; a_in_data = 32'h5555_0005; a_flush = 1; cyc();
    a_flush = 0; a_in_valid = 0;
    chk("t4b_occ", 64'(a_occ), 64'(0));
    cyc();
    chk("t4b_delivered", 64'(a_ndel - base), 64'(1));

    // Single-entry build: combinational in_ready
    base = b_ndel;
    b_in_valid = 1; b_in_data = 32'hB000_0000; b_in_ctrl = 7'h5A; cyc();
    chk("t5_in_ready_stall", 64'(b_in_ready), 64'(0));
    b_out_ready = 1;
    #1;
    chk("t5_in_ready_comb", 64'(b_in_ready), 64'(1));
    for (int k = 1; k <= 6; k++) begin
      b_in_data = 32'hB000_0000 + DW'(k); b_in_ctrl = CW'(k * 9);
      cyc();
    end
    b_in_valid = 0;
    cyc(); cyc();
    chk("t5_delivered", 64'(b_ndel - base), 64'(7));

    // Asynchronous reset between edges with both entries occupied
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h6666_0006; a_in_ctrl = 7'h7F; cyc();
    a_in_data = 32'h7777_0007; cyc();
    a_in_data = 32'h8888_0008;
    b_in_valid = 1; b_out_ready = 0; b_in_data = 32'h9999_0009; cyc();
    #2;
    rst_n = 0;
    #1;
    chk("t6_a_out_valid", 64'(a_out_valid), 64'(0));
    chk("t6_a_in_ready", 64'(a_in_ready), 64'(1));
    chk("t6_a_occ", 64'(a_occ), 64'(0));
    chk("t6_a_out_ctrl", 64'(a_out_ctrl), 64'(FV));
    chk("t6_a_out_data", 64'(a_out_data), 64'(0));
    chk("t6_b_out_valid", 64'(b_out_valid), 64'(0));
    a_in_valid = 0; b_in_valid = 0;
    cyc();
    rst_n = 1;
    cyc(); cyc();
    chk("t6_post_occ", 64'(a_occ), 64'(0));

    // Nothing left in flight
    a_out_ready = 1; b_out_ready = 1;
    for (int t = 0; t < 20 && (a_q.size() != 0 || b_q.size() != 0); t++) cyc();
    chk("a_drain", 64'(a_q.size()), 64'(0));
    chk("b_drain", 64'(b_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
